// File: rtl/branch_resolve_sched_pkg.sv
// Shared types for the branch resolution scheduler.
//   BRS_MASK_WIDTH    : branch tag count (one slot per tag)
//   B_MASK            : one bit per branch tag
//   BR_RESOLVE_PACKET : {valid, one-hot tag, dep_mask of older unresolved branches, mispred}
//   BRS_SLOT          : per-tag buffered resolution {valid, dep_mask, mispred}
package branch_resolve_sched_pkg;

    localparam int BRS_MASK_WIDTH = 4;

    typedef logic [BRS_MASK_WIDTH-1:0] B_MASK;

    typedef struct packed {
        logic  valid;
        B_MASK tag;
        B_MASK dep_mask;
        logic  mispred;
    } BR_RESOLVE_PACKET;

    typedef struct packed {
        logic  valid;
        B_MASK dep_mask;
        logic  mispred;
    } BRS_SLOT;

endpackage

// File: rtl/branch_resolve_sched_sva.sv
// Assertion checker for branch_resolve_sched: output encoding and input legality.
//   clock, reset  : sampling clock and reset (checks disabled during reset)
//   br_in         : resolution packets from the branch units
//   b_mm_resolve  : one-hot tag presented this cycle
//   b_mm_mispred  : presented resolution is a mispredict
//   pending_mask  : slot valid bits
module branch_resolve_sched_sva
    import branch_resolve_sched_pkg::*;
#(
    parameter int NUM_BR_UNITS = 2
) (
    input logic             clock,
    input logic             reset,
    input BR_RESOLVE_PACKET br_in [NUM_BR_UNITS],
    input B_MASK            b_mm_resolve,
    input logic             b_mm_mispred,
    input B_MASK            pending_mask
);

    a_resolve_onehot0: assert property (@(posedge clock) disable iff (reset)
        $onehot0(b_mm_resolve));

    a_mispred_has_tag: assert property (@(posedge clock) disable iff (reset)
        b_mm_mispred |-> (b_mm_resolve != '0));

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_BR_UNITS; gi++) begin : g_unit
            a_tag_onehot: assert property (@(posedge clock) disable iff (reset)
                br_in[gi].valid |-> $onehot(br_in[gi].tag));
            a_tag_free: assert property (@(posedge clock) disable iff (reset)
                br_in[gi].valid |-> ((br_in[gi].tag & pending_mask) == '0));
            a_tag_not_selected: assert property (@(posedge clock) disable iff (reset)
                br_in[gi].valid |-> ((br_in[gi].tag & b_mm_resolve) == '0));
            a_dep_not_self: assert property (@(posedge clock) disable iff (reset)
                br_in[gi].valid |-> ((br_in[gi].tag & br_in[gi].dep_mask) == '0));
            for (gj = gi + 1; gj < NUM_BR_UNITS; gj++) begin : g_pair
                a_tag_unique: assert property (@(posedge clock) disable iff (reset)
                    (br_in[gi].valid && br_in[gj].valid) |-> (br_in[gi].tag != br_in[gj].tag));
            end
        end
    endgenerate

endmodule

// File: rtl/lowest_onehot_sel.sv
// Combinational picker: returns the lowest set bit of req as a one-hot grant.
//   req : request vector
//   gnt : one-hot lowest request, or zero when req is zero
module lowest_onehot_sel #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt
);

    // Two's-complement trick isolates the least significant set bit.
    assign gnt = req & (~req + WIDTH'(1));

endmodule

// File: rtl/branch_resolve_sched.sv
// Branch resolution scheduler. Buffers resolutions from the branch units in
// one slot per tag and presents one per cycle to the branch stack, oldest
// mispredict first, otherwise the lowest-index correct resolution.
//   clock, reset  : clock and asynchronous active-high reset
//   br_in         : up to NUM_BR_UNITS resolutions per cycle
//   b_mm_resolve  : one-hot tag resolved this cycle (0 when idle)
//   b_mm_mispred  : that resolution is a mispredict
//   pending_mask  : slot valid bits
module branch_resolve_sched
    import branch_resolve_sched_pkg::*;
#(
    parameter int NUM_BR_UNITS = 2,
    parameter int B_MASK_WIDTH = BRS_MASK_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  BR_RESOLVE_PACKET br_in [NUM_BR_UNITS],
    output B_MASK            b_mm_resolve,
    output logic             b_mm_mispred,
    output B_MASK            pending_mask
);

    B_MASK valid_vec;
    B_MASK mp_vec;
    B_MASK corr_vec;
    B_MASK cand_vec;
    B_MASK cand_pick;
    B_MASK corr_pick;
    B_MASK sel;
    logic  sel_mp;

    genvar gi;
    generate
        for (gi = 0; gi < B_MASK_WIDTH; gi++) begin : g_slot
            BRS_SLOT slot_reg;
            BRS_SLOT slot_next;

            assign valid_vec[gi] = slot_reg.valid;
            assign mp_vec[gi]    = slot_reg.valid & slot_reg.mispred;
            assign corr_vec[gi]  = slot_reg.valid & ~slot_reg.mispred;
            // A mispredict is the oldest when it depends on no other pending mispredict.
            assign cand_vec[gi]  = mp_vec[gi] & ((slot_reg.dep_mask & mp_vec) == '0);

            always_comb begin
                slot_next          = slot_reg;
                // Stripping sel is harmless on a mispredict: a surviving slot
                // never has that bit set, otherwise it would be squashed below.
                slot_next.dep_mask = slot_reg.dep_mask & ~sel;
                if (sel[gi] || (sel_mp && ((slot_reg.dep_mask & sel) != '0))) begin
                    slot_next = '0;
                end
                for (int u = 0; u < NUM_BR_UNITS; u++) begin
                    if (br_in[u].valid && br_in[u].tag[gi] &&
                        !(sel_mp && ((br_in[u].dep_mask & sel) != '0))) begin
                        slot_next.valid    = 1'b1;
                        slot_next.dep_mask = br_in[u].dep_mask & ~sel;
                        slot_next.mispred  = br_in[u].mispred;
                    end
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    slot_reg <= '0;
                end else begin
                    slot_reg <= slot_next;
                end
            end
        end
    endgenerate

    // Exactly one candidate is expected; the picker keeps the output one-hot regardless.
    lowest_onehot_sel #(.WIDTH(B_MASK_WIDTH)) u_mp_sel (
        .req (cand_vec),
        .gnt (cand_pick)
    );

    lowest_onehot_sel #(.WIDTH(B_MASK_WIDTH)) u_corr_sel (
        .req (corr_vec),
        .gnt (corr_pick)
    );

    assign sel_mp       = |cand_vec;
    assign sel          = sel_mp ? cand_pick : corr_pick;
    assign b_mm_resolve = sel;
    assign b_mm_mispred = sel_mp;
    assign pending_mask = valid_vec;

    branch_resolve_sched_sva #(.NUM_BR_UNITS(NUM_BR_UNITS)) u_sva (
        .clock        (clock),
        .reset        (reset),
        .br_in        (br_in),
        .b_mm_resolve (b_mm_resolve),
        .b_mm_mispred (b_mm_mispred),
        .pending_mask (pending_mask)
    );

endmodule

// File: tb/tb_branch_resolve_sched.sv
// Directed testbench for branch_resolve_sched with hand-computed expectations.
module tb_branch_resolve_sched;
    import branch_resolve_sched_pkg::*;

    localparam int NUM_BR_UNITS = 2;

    logic             clock;
    logic             reset;
    BR_RESOLVE_PACKET br_in [NUM_BR_UNITS];
    B_MASK            b_mm_resolve;
    logic             b_mm_mispred;
    B_MASK            pending_mask;

    int n_cmp;
    int n_bad;

    branch_resolve_sched #(
        .NUM_BR_UNITS (NUM_BR_UNITS),
        .B_MASK_WIDTH (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .br_in        (br_in),
        .b_mm_resolve (b_mm_resolve),
        .b_mm_mispred (b_mm_mispred),
        .pending_mask (pending_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end else begin
            $display("ok   %s: %b", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        for (int u = 0; u < NUM_BR_UNITS; u++) br_in[u] = '0;
    endtask

    task automatic drive(input int u, input logic [3:0] tag, input logic [3:0] dep, input logic mp);
        br_in[u].valid    = 1'b1;
        br_in[u].tag      = tag;
        br_in[u].dep_mask = dep;
        br_in[u].mispred  = mp;
    endtask

    task automatic check_out(input string tag, input logic [3:0] res, input logic mp, input logic [3:0] pend);
        check_eq({tag, ".resolve"}, {4'b0, b_mm_resolve}, {4'b0, res});
        check_eq({tag, ".mispred"}, {7'b0, b_mm_mispred}, {7'b0, mp});
        check_eq({tag, ".pending"}, {4'b0, pending_mask}, {4'b0, pend});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        clear_inputs();
        #2;
        check_out("reset_init", 4'b0000, 1'b0, 4'b0000);
        #5 reset = 1'b0;

        // Single correct resolve
        tick();
        drive(0, 4'b0010, 4'b0000, 1'b0);
        tick(); clear_inputs();
        check_out("single_c2", 4'b0010, 1'b0, 4'b0010);
        tick();
        check_out("single_c3", 4'b0000, 1'b0, 4'b0000);

        // Dual correct resolves drain in ascending tag order
        drive(0, 4'b0100, 4'b0000, 1'b0);
        drive(1, 4'b0001, 4'b0000, 1'b0);
        tick(); clear_inputs();
        check_out("dual_c2", 4'b0001, 1'b0, 4'b0101);
        tick();
        check_out("dual_c3", 4'b0100, 1'b0, 4'b0100);
        tick();
        check_out("dual_c4", 4'b0000, 1'b0, 4'b0000);

        // Mispredict takes priority over a lower-index correct resolve
        drive(0, 4'b0001, 4'b0000, 1'b0);
        drive(1, 4'b0100, 4'b0000, 1'b1);
        tick(); clear_inputs();
        check_out("mppri_c2", 4'b0100, 1'b1, 4'b0101);
        tick();
        check_out("mppri_c3", 4'b0001, 1'b0, 4'b0001);
        tick();
        check_out("mppri_c4", 4'b0000, 1'b0, 4'b0000);

        // Oldest mispredict selected, younger mispredict squashed
        drive(0, 4'b0010, 4'b0000, 1'b1);
        drive(1, 4'b1000, 4'b0010, 1'b1);
        tick(); clear_inputs();
        check_out("oldest_c2", 4'b0010, 1'b1, 4'b1010);
        tick();
        check_out("oldest_c3", 4'b0000, 1'b0, 4'b0000);

        // Same-cycle arrival squashed by the mispredict selected that cycle
        drive(0, 4'b0100, 4'b0000, 1'b1);
        tick(); clear_inputs();
        check_out("sqarr_cN", 4'b0100, 1'b1, 4'b0100);
        drive(0, 4'b0001, 4'b0100, 1'b0);
        tick(); clear_inputs();
        check_out("sqarr_cN1", 4'b0000, 1'b0, 4'b0000);

        // Same-cycle arrival has the correctly resolved tag stripped from its dep_mask
        drive(0, 4'b0100, 4'b0000, 1'b0);
        tick(); clear_inputs();
        check_out("deparr_cN", 4'b0100, 1'b0, 4'b0100);
        drive(0, 4'b1000, 4'b0100, 1'b1);
        tick(); clear_inputs();
        check_out("deparr_cN1", 4'b1000, 1'b1, 4'b1000);
        check_eq("deparr_stored_dep", {4'b0, dut.g_slot[3].slot_reg.dep_mask}, 8'b0);
        tick();
        check_out("deparr_cN2", 4'b0000, 1'b0, 4'b0000);

        // Dependent correct resolves: stripped dep does not block the younger one
        drive(0, 4'b0001, 4'b0000, 1'b0);
        drive(1, 4'b0010, 4'b0001, 1'b0);
        tick(); clear_inputs();
        check_out("dep_c2", 4'b0001, 1'b0, 4'b0011);
        tick();
        check_out("dep_c3", 4'b0010, 1'b0, 4'b0010);
        tick();

        // Reset mid-cycle with slots 0101 pending clears everything without an edge
        drive(0, 4'b0001, 4'b0000, 1'b0);
        drive(1, 4'b0100, 4'b0000, 1'b0);
        tick(); clear_inputs();
        check_out("rst_pre", 4'b0001, 1'b0, 4'b0101);
        #2 reset = 1'b1;
        #1;
        check_out("rst_mid", 4'b0000, 1'b0, 4'b0000);
        #3 reset = 1'b0;
        tick();
        check_out("rst_post", 4'b0000, 1'b0, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
